// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer: dispatches decoded multicycle ops to execution units and sequences their write-back
module multicycle_sequencer #(
   parameter int NUM_UNITS = 2,
   parameter int TIMEOUT   = 64,
   parameter int UW        = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 mc_req,
   input  logic [UW-1:0]        mc_unit,
   input  logic [1:0]           mc_mode,
   input  logic                 stall,
   input  logic                 flush,
   input  logic [NUM_UNITS-1:0] unit_done,
   output logic [NUM_UNITS-1:0] unit_start,
   output logic [NUM_UNITS-1:0] unit_abort,
   output logic [1:0]           unit_mode,
   output logic                 hold_pc,
   output logic                 result_write,
   output logic [UW-1:0]        result_sel,
   output logic                 busy,
   output logic                 fault,
   output logic [9:0]           last_latency
);
   typedef enum logic [2:0] {IDLE, START, WAIT, WB, FAULT} state_t;
   state_t state, state_nx;
   logic [UW-1:0] sel;
   logic [9:0] cnt;
   logic [NUM_UNITS-1:0] sel_oh, req_oh;
   logic accept, done, timeout;
   assign sel_oh = NUM_UNITS'(1) << sel;
   assign req_oh = NUM_UNITS'(1) << mc_unit;
   assign done = |(unit_done & sel_oh);
   assign timeout = cnt == 10'(TIMEOUT - 1);
   // a request is refused while the previous result is being written
   assign accept = state == IDLE && mc_req && !stall && !flush && !result_write;
   assign result_sel = sel;
   assign hold_pc = rst_n && ((state == IDLE || state == WB) ? stall : 1'b1);
   // next-state selection; flush returns to IDLE from anywhere
   always_comb begin
      state_nx = state;
      if (flush) state_nx = IDLE;
      else case (state)
         IDLE:    if (accept) state_nx = 32'(mc_unit) < NUM_UNITS ? START : FAULT;
         START:   state_nx = WAIT;
         WAIT:    state_nx = done ? WB : timeout ? FAULT : WAIT;
         WB:      state_nx = stall ? WB : IDLE;
         FAULT:   state_nx = FAULT;
         default: state_nx = IDLE;
      endcase
   end
   // state, registered outputs, saturating wait counter and latched op
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         sel          <= '0;
         unit_mode    <= '0;
         cnt          <= '0;
         last_latency <= '0;
         unit_start   <= '0;
         unit_abort   <= '0;
         result_write <= 1'b0;
         busy         <= 1'b0;
         fault        <= 1'b0;
      end else begin
         state        <= state_nx;
         busy         <= state_nx != IDLE;
         fault        <= state_nx == FAULT;
         unit_start   <= state_nx == START ? req_oh : '0;
         unit_abort   <= (flush && (state == START || state == WAIT)) ? sel_oh : '0;
         result_write <= state == WB && !stall && !flush;
         cnt          <= state == WAIT ? cnt + {9'd0, cnt != 10'h3ff} : '0;
         if (accept) begin
            sel       <= mc_unit;
            unit_mode <= mc_mode;
         end
         if (state == WAIT && done && !flush) last_latency <= cnt + {9'd0, cnt != 10'h3ff};
      end
   end
endmodule
